// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory responder.
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_e;

   // Counter preload for a given accept-to-response latency (1..15).
   function automatic logic [CNT_W-1:0] lat_preload(input int latency);
      return CNT_W'(latency - 1);
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake plus program-load port of the instruction memory.
interface imem_responder_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              load_en;
   logic [ADDR_W-3:0] load_idx;
   logic [DATA_W-1:0] load_data;

   modport master (
      output req_valid, req_addr, rsp_ready, load_en, load_idx, load_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, load_en, load_idx, load_data,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port, never reset.
module imem_array #(
   parameter int IDX_W  = 3,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  ridx,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**IDX_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[widx] <= wdata;
      end
   end

   // Async read sees the pre-edge contents, so a same-cycle load returns the old word.
   assign rdata = mem[ridx];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder; one fetch in flight at a time.
// Optional misaligned-address error reporting: define IMEM_MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request, req_ready=1
// WAIT  | word latched, counting down to the response edge
// RESP  | rsp_valid=1, data held until rsp_ready
module imem_responder
   import mips_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = INSTR_W,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   imem_responder_if.slave   bus
);

   localparam int               IDX_W    = ADDR_W - 2;
   localparam logic [CNT_W-1:0] CNT_INIT = lat_preload(LATENCY);

   imem_state_e       state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] pend_data;
   logic              pend_err;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_err_q;

   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] fetch_word;
   logic              fetch_err;

   imem_array #(
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (bus.load_en),
      .widx  (bus.load_idx),
      .wdata (bus.load_data),
      .ridx  (bus.req_addr[ADDR_W-1:2]),
      .rdata (rd_word)
   );

`ifdef IMEM_MISALIGN_CHECK_EN
   always_comb begin
      fetch_err  = |bus.req_addr[1:0];
      fetch_word = fetch_err ? '0 : rd_word;
   end
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^bus.req_addr[1:0];

   always_comb begin
      fetch_err  = 1'b0;
      fetch_word = rd_word;
   end
`endif

   // LATENCY=1 still passes through WAIT with a zero count, keeping the
   // response exactly LATENCY edges after the accept for every setting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         pend_data   <= '0;
         pend_err    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  pend_data <= fetch_word;
                  pend_err  <= fetch_err;
                  cnt       <= CNT_INIT;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= pend_data;
                  rsp_err_q   <= pend_err;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state       <= IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder at LATENCY 2 (main), 1 and 15.
module tb_imem_responder;

   localparam int AW = 5;
   localparam int DW = mips_pkg::INSTR_W;

`ifdef IMEM_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic          rsp_ready = 1'b0;
   logic          load_en   = 1'b0;
   logic [AW-3:0] load_idx  = '0;
   logic [DW-1:0] load_data = '0;

   imem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
   imem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if_1 ();
   imem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if_15 ();

   assign {if_a.req_valid, if_a.req_addr, if_a.rsp_ready, if_a.load_en, if_a.load_idx, if_a.load_data} =
          {req_valid, req_addr, rsp_ready, load_en, load_idx, load_data};
   assign {if_1.req_valid, if_1.req_addr, if_1.rsp_ready, if_1.load_en, if_1.load_idx, if_1.load_data} =
          {req_valid, req_addr, rsp_ready, load_en, load_idx, load_data};
   assign {if_15.req_valid, if_15.req_addr, if_15.rsp_ready, if_15.load_en, if_15.load_idx, if_15.load_data} =
          {req_valid, req_addr, rsp_ready, load_en, load_idx, load_data};

   imem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2))  dut_a  (.clk(clk), .rst_n(rst_n), .bus(if_a));
   imem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1))  dut_1  (.clk(clk), .rst_n(rst_n), .bus(if_1));
   imem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(15)) dut_15 (.clk(clk), .rst_n(rst_n), .bus(if_15));

   logic [DW-1:0] model_mem [8];
   int checks = 0;
   int errors = 0;

   function automatic void model_expect(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic e);
      if (MIS_EN && a[1:0] != 2'b00) begin
         d = '0;
         e = 1'b1;
      end else begin
         d = model_mem[a[4:2]];
         e = 1'b0;
      end
   endfunction

   task automatic do_load(input logic [2:0] idx, input logic [DW-1:0] data);
      @(negedge clk);
      load_en = 1'b1; load_idx = idx; load_data = data;
      @(negedge clk);
      load_en = 1'b0;
      model_mem[idx] = data;
   endtask

   // Runs one fetch on the LATENCY=2 instance and reports what it observed.
   task automatic fetch(input logic [AW-1:0] addr, input bit same_load, input logic [2:0] lidx,
                        input logic [DW-1:0] ldata, input bit late_load, input int stall,
                        output int lat, output logic [DW-1:0] data, output logic err,
                        output bit zero_ok, output bit hold_ok, output bit ready_low_ok);
      int n = 0;
      @(negedge clk);
      while (!if_a.req_ready && n < 50) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_addr = addr; rsp_ready = (stall == 0);
      if (same_load) begin load_en = 1'b1; load_idx = lidx; load_data = ldata; end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = AW'($urandom);
      if (same_load) begin model_mem[lidx] = ldata; load_en = 1'b0; end
      lat = 0; zero_ok = 1'b1; ready_low_ok = 1'b1; hold_ok = 1'b1;
      while (!if_a.rsp_valid && lat < 40) begin
         if (if_a.rsp_data !== '0) zero_ok = 1'b0;
         if (if_a.req_ready !== 1'b0) ready_low_ok = 1'b0;
         if (late_load && lat == 0) begin
            load_en = 1'b1; load_idx = addr[4:2]; load_data = $urandom;
         end
         @(posedge clk); lat++;
         @(negedge clk);
         if (load_en) begin model_mem[load_idx] = load_data; load_en = 1'b0; end
      end
      data = if_a.rsp_data;
      err  = if_a.rsp_err;
      for (int i = 0; i < stall; i++) begin
         if (if_a.rsp_valid !== 1'b1 || if_a.rsp_data !== data || if_a.rsp_err !== err ||
             if_a.req_ready !== 1'b0) hold_ok = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      if (if_a.rsp_valid !== 1'b1 || if_a.rsp_data !== data) hold_ok = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #13;
      checks++;
      if (if_a.rsp_valid !== 1'b0 || if_1.rsp_valid !== 1'b0 || if_15.rsp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_rsp_valid: got %b%b%b expected 000", if_a.rsp_valid, if_1.rsp_valid, if_15.rsp_valid);
      end
      checks++;
      if (if_a.rsp_data !== '0 || if_a.rsp_err !== 1'b0) begin
         errors++; $display("FAIL reset_rsp_data: got %h/%b expected 0/0", if_a.rsp_data, if_a.rsp_err);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (if_a.req_ready !== 1'b1 || if_1.req_ready !== 1'b1 || if_15.req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_req_ready: got %b%b%b expected 111", if_a.req_ready, if_1.req_ready, if_15.req_ready);
      end
      for (int i = 0; i < 8; i++) do_load(3'(i), 32'($urandom));
   endtask

   task automatic test_basic();
      int lat; logic [DW-1:0] d, ed; logic e, ee; bit zok, hok, rok;
      do_load(3'd1, 32'h2002000A);
      model_expect(5'd4, ed, ee);
      fetch(5'd4, 1'b0, 3'd0, '0, 1'b0, 0, lat, d, e, zok, hok, rok);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
      checks++;
      if (d !== 32'h2002000A || d !== ed) begin errors++; $display("FAIL basic_data: got %h expected %h", d, ed); end
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", e); end
      checks++;
      if (!zok || !rok) begin errors++; $display("FAIL basic_idle_outputs: zero_ok %b ready_low_ok %b expected 1 1", zok, rok); end
      checks++;
      if (if_a.req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", if_a.req_ready); end
   endtask

   task automatic test_backpressure();
      int lat; logic [DW-1:0] d, ed; logic e, ee; bit zok, hok, rok;
      logic [AW-1:0] a;
      a = {3'($urandom_range(0, 7)), 2'b00};
      model_expect(a, ed, ee);
      fetch(a, 1'b0, 3'd0, '0, 1'b0, 3, lat, d, e, zok, hok, rok);
      checks++;
      if (!hok) begin errors++; $display("FAIL bp_hold: got hold_ok 0 expected 1"); end
      checks++;
      if (d !== ed || lat !== 2) begin errors++; $display("FAIL bp_data: got %h lat %0d expected %h lat 2", d, lat, ed); end
      checks++;
      if (if_a.req_ready !== 1'b1 || if_a.rsp_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release: got ready %b valid %b expected 1 0", if_a.req_ready, if_a.rsp_valid);
      end
   endtask

   task automatic test_read_before_write();
      int lat; logic [DW-1:0] d, ed; logic e, ee; bit zok, hok, rok;
      do_load(3'd2, 32'h00000020);
      model_expect(5'd8, ed, ee);
      fetch(5'd8, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 0, lat, d, e, zok, hok, rok);
      checks++;
      if (d !== 32'h00000020 || d !== ed) begin errors++; $display("FAIL rbw_old: got %h expected 00000020", d); end
      model_expect(5'd8, ed, ee);
      fetch(5'd8, 1'b0, 3'd0, '0, 1'b0, 0, lat, d, e, zok, hok, rok);
      checks++;
      if (d !== 32'hFFFFFFFF || d !== ed) begin errors++; $display("FAIL rbw_new: got %h expected ffffffff", d); end
   endtask

   task automatic test_misalign();
      int lat; logic [DW-1:0] d, ed; logic e, ee; bit zok, hok, rok;
      model_expect(5'd6, ed, ee);
      fetch(5'd6, 1'b0, 3'd0, '0, 1'b0, 1, lat, d, e, zok, hok, rok);
      checks++;
      if (d !== ed || e !== ee || lat !== 2) begin
         errors++; $display("FAIL misalign: got %h/%b lat %0d expected %h/%b lat 2", d, e, lat, ed, ee);
      end
   endtask

   task automatic test_late_load();
      int lat; logic [DW-1:0] d, ed; logic e, ee; bit zok, hok, rok;
      model_expect(5'd12, ed, ee);
      fetch(5'd12, 1'b0, 3'd0, '0, 1'b1, 1, lat, d, e, zok, hok, rok);
      checks++;
      if (d !== ed || !hok) begin errors++; $display("FAIL late_load: got %h hold %b expected %h hold 1", d, hok, ed); end
   endtask

   task automatic test_random();
      int lat; logic [DW-1:0] d, ed; logic e, ee; bit zok, hok, rok;
      logic [AW-1:0] a;
      for (int it = 0; it < 24; it++) begin
         a = AW'($urandom_range(0, 31));
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
         model_expect(a, ed, ee);
         fetch(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), lat, d, e, zok, hok, rok);
         checks++;
         if (d !== ed || e !== ee || lat !== 2 || !zok || !hok || !rok) begin
            errors++;
            $display("FAIL random_%0d addr %h: got %h/%b lat %0d flags %b%b%b expected %h/%b lat 2 flags 111",
                     it, a, d, e, lat, zok, hok, rok, ed, ee);
         end
      end
   endtask

   task automatic test_reset_wait();
      int lat; logic [DW-1:0] d, ed; logic e, ee; bit zok, hok, rok;
      bit seen = 1'b0;
      do_load(3'd5, 32'hCAFE0005);
      @(negedge clk);
      req_valid = 1'b1; req_addr = 5'd20; rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      if (if_a.rsp_valid) seen = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (if_a.rsp_valid) seen = 1'b1;
      end
      rsp_ready = 1'b0;
      checks++;
      if (seen) begin errors++; $display("FAIL reset_wait_drop: got rsp_valid 1 expected 0"); end
      checks++;
      if (if_a.req_ready !== 1'b1) begin errors++; $display("FAIL reset_wait_ready: got %b expected 1", if_a.req_ready); end
      model_expect(5'd20, ed, ee);
      fetch(5'd20, 1'b0, 3'd0, '0, 1'b0, 0, lat, d, e, zok, hok, rok);
      checks++;
      if (d !== 32'hCAFE0005 || d !== ed) begin errors++; $display("FAIL reset_wait_mem: got %h expected cafe0005", d); end
   endtask

   task automatic test_latency_sweep();
      int l1 = -1, l2 = -1, l15 = -1, n = 0;
      logic [DW-1:0] d1 = '0, d15 = '0, w7;
      rsp_ready = 1'b1;
      @(negedge clk);
      while (!(if_a.req_ready && if_1.req_ready && if_15.req_ready) && n < 60) begin @(negedge clk); n++; end
      w7 = 32'($urandom);
      do_load(3'd7, w7);
      req_valid = 1'b1; req_addr = 5'd28;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      for (int edge_n = 1; edge_n <= 20; edge_n++) begin
         @(posedge clk); @(negedge clk);
         if (if_1.rsp_valid && l1 < 0) begin l1 = edge_n; d1 = if_1.rsp_data; end
         if (if_a.rsp_valid && l2 < 0) l2 = edge_n;
         if (if_15.rsp_valid && l15 < 0) begin l15 = edge_n; d15 = if_15.rsp_data; end
      end
      rsp_ready = 1'b0;
      checks++;
      if (l1 !== 1 || l2 !== 2 || l15 !== 15) begin
         errors++; $display("FAIL latency_sweep: got %0d/%0d/%0d expected 1/2/15", l1, l2, l15);
      end
      checks++;
      if (d1 !== model_mem[7] || d15 !== model_mem[7]) begin
         errors++; $display("FAIL last_word: got %h/%h expected %h", d1, d15, model_mem[7]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_read_before_write();
      test_misalign();
      test_late_load();
      test_random();
      test_reset_wait();
      test_latency_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
